rrf_alloc_mw: RTL and testbench

RRF_ALLOC_MW -- requirements
Module: rrf_alloc_mw

---
 rtl/rrf_alloc_mw.sv | 107 ++++++++++
 tb/tb_rrf_alloc_mw.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rrf_alloc_mw.sv
// Rename-register-file allocator: multi-wide circular free list with in-order commit
// reclaim and flush rollback of speculative allocations.
module rrf_alloc_mw #(
    parameter int unsigned RRF_NUM = 64,
    parameter int unsigned ALLOC_W = 2,
    parameter int unsigned COM_W   = 2,
    localparam int unsigned RRF_SEL = $clog2(RRF_NUM),
    localparam int unsigned CNT_W   = $clog2(COM_W + 1),
    localparam int unsigned REQ_CW  = $clog2(ALLOC_W + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [ALLOC_W-1:0]         req_en_i,
    input  logic                       stall_dp_i,
    input  logic [CNT_W-1:0]           com_inst_num_i,
    input  logic                       flush_i,
    output logic                       rrf_allocatable_o,
    output logic                       alloc_fire_o,
    output logic [ALLOC_W*RRF_SEL-1:0] dst_rrftag_o,
    output logic [ALLOC_W-1:0]         dst_valid_o,
    output logic [RRF_SEL:0]           freenum_o,
    output logic [RRF_SEL-1:0]         rrfptr_o,
    output logic [RRF_SEL-1:0]         comptr_o,
    output logic                       rrfcyc_o,
    output logic                       nextrrfcyc_o,
    output logic                       com_err_o
);

    localparam logic [RRF_SEL:0] NumEnt = (RRF_SEL + 1)'(RRF_NUM);

    logic [RRF_SEL-1:0] rrfptr_q, rrfptr_d, comptr_q, comptr_d;
    logic [RRF_SEL:0]   freenum_q, freenum_d;
    logic               rrfcyc_q, rrfcyc_d, comcyc_q, comcyc_d, com_err_q, com_err_d;

    logic [REQ_CW-1:0]  ofs;
    logic [REQ_CW-1:0]  reqcnt;
    logic [RRF_SEL:0]   reqcnt_ext, occupied, com_req, com_amt, alloc_amt;
    logic [RRF_SEL:0]   rrf_sum, com_sum;
    logic               over_com;

    // Each slot's tag is offset by the number of enabled slots below it.
    always_comb begin
        ofs          = '0;
        dst_rrftag_o = '0;
        for (int k = 0; k < int'(ALLOC_W); k++) begin
            dst_rrftag_o[k*RRF_SEL +: RRF_SEL] = rrfptr_q + RRF_SEL'(ofs);
            ofs = ofs + REQ_CW'(req_en_i[k]);
        end
        reqcnt = ofs;
    end

    always_comb begin
        reqcnt_ext        = (RRF_SEL + 1)'(reqcnt);
        rrf_allocatable_o = (freenum_q >= reqcnt_ext);
        alloc_fire_o      = rrf_allocatable_o & ~stall_dp_i & ~flush_i & (reqcnt != '0);
        dst_valid_o       = req_en_i & {ALLOC_W{alloc_fire_o}};
        alloc_amt         = alloc_fire_o ? reqcnt_ext : '0;

        occupied = NumEnt - freenum_q;
        com_req  = (RRF_SEL + 1)'(com_inst_num_i);
        over_com = (com_req > occupied);
        com_amt  = over_com ? occupied : com_req;

        // Sums stay below 2*RRF_NUM, so the top bit flags a pointer wrap.
        rrf_sum      = {1'b0, rrfptr_q} + reqcnt_ext;
        nextrrfcyc_o = alloc_fire_o & rrf_sum[RRF_SEL];
        com_sum      = {1'b0, comptr_q} + com_amt;
        comptr_d     = com_sum[RRF_SEL-1:0];
        comcyc_d     = comcyc_q ^ com_sum[RRF_SEL];
        com_err_d    = com_err_q | over_com;

        if (flush_i) begin
            rrfptr_d  = comptr_d;
            rrfcyc_d  = comcyc_d;
            freenum_d = NumEnt;
        end else begin
            rrfptr_d  = alloc_fire_o ? rrf_sum[RRF_SEL-1:0] : rrfptr_q;
            rrfcyc_d  = rrfcyc_q ^ nextrrfcyc_o;
            freenum_d = freenum_q - alloc_amt + com_amt;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rrfptr_q  <= '0;
            comptr_q  <= '0;
            freenum_q <= NumEnt;
            rrfcyc_q  <= 1'b0;
            comcyc_q  <= 1'b0;
            com_err_q <= 1'b0;
        end else begin
            rrfptr_q  <= rrfptr_d;
            comptr_q  <= comptr_d;
            freenum_q <= freenum_d;
            rrfcyc_q  <= rrfcyc_d;
            comcyc_q  <= comcyc_d;
            com_err_q <= com_err_d;
        end
    end

    assign freenum_o = freenum_q;
    assign rrfptr_o  = rrfptr_q;
    assign comptr_o  = comptr_q;
    assign rrfcyc_o  = rrfcyc_q;
    assign com_err_o = com_err_q;

endmodule

// File: tb/tb_rrf_alloc_mw.sv
// Bench for rrf_alloc_mw: directed corner scenarios plus randomized traffic checked
// against a model built from running allocation/commit totals.
module tb_rrf_alloc_mw;

    localparam int N = 64;

    logic        clk, reset_i;
    logic [1:0]  req;
    logic        stall, flush;
    logic [1:0]  com;
    logic        allocatable, fire, nxtcyc, rrfcyc, com_err;
    logic [11:0] tags;
    logic [1:0]  valid;
    logic [6:0]  freenum;
    logic [5:0]  rrfptr, comptr;

    int n_cmp = 0;
    int n_err = 0;

    // Model: total entries ever allocated / committed; everything else derives from these.
    longint a_tot, c_tot;
    bit     err_m;

    rrf_alloc_mw #(.RRF_NUM(64), .ALLOC_W(2), .COM_W(2)) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .req_en_i         (req),
        .stall_dp_i       (stall),
        .com_inst_num_i   (com),
        .flush_i          (flush),
        .rrf_allocatable_o(allocatable),
        .alloc_fire_o     (fire),
        .dst_rrftag_o     (tags),
        .dst_valid_o      (valid),
        .freenum_o        (freenum),
        .rrfptr_o         (rrfptr),
        .comptr_o         (comptr),
        .rrfcyc_o         (rrfcyc),
        .nextrrfcyc_o     (nxtcyc),
        .com_err_o        (com_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    function automatic logic [37:0] model_out(input logic [1:0] r, input logic st, input logic fl);
        int  cnt  = int'(r[0]) + int'(r[1]);
        int  free = N - int'(a_tot - c_tot);
        bit  al   = (free >= cnt);
        bit  fi   = al && !st && !fl && (cnt != 0);
        bit  nx   = fi && ((int'(a_tot % N) + cnt) >= N);
        logic [5:0] t0 = 6'(a_tot % N);
        logic [5:0] t1 = 6'((a_tot + longint'(r[0])) % N);
        return {al, fi, t1, t0, r & {2{fi}}, 7'(free), 6'(a_tot % N), 6'(c_tot % N),
                1'((a_tot / N) % 2), nx, err_m};
    endfunction

    task automatic model_step();
        int     cnt  = int'(req[0]) + int'(req[1]);
        longint occ  = a_tot - c_tot;
        bit     fi   = ((N - occ) >= cnt) && !stall && !flush && (cnt != 0);
        longint cc   = (longint'(com) > occ) ? occ : longint'(com);
        if (longint'(com) > occ) err_m = 1'b1;
        c_tot += cc;
        if (flush) a_tot = c_tot;
        else if (fi) a_tot += cnt;
    endtask

    task automatic drive(input logic [1:0] r, input logic st, input logic fl, input logic [1:0] c);
        req = r; stall = st; flush = fl; com = c;
        #1;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_i = 1'b1;
        req = 2'b00; stall = 1'b0; flush = 1'b0; com = 2'd0;
        a_tot = 0; c_tot = 0; err_m = 1'b0;
        @(negedge clk);
        reset_i = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        drive(2'b11, 1'b0, 1'b0, 2'd0);
        n_cmp++;
        if ({freenum, rrfptr, comptr, rrfcyc, com_err} !== {7'd64, 6'd0, 6'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: got free=%0d rp=%0d cp=%0d cyc=%b err=%b, need 64 0 0 0 0",
                     freenum, rrfptr, comptr, rrfcyc, com_err);
        end
        n_cmp++;
        if (tags !== {6'd1, 6'd0}) begin
            n_err++;
            $display("FAIL reset_tags: got %h, need %h", tags, {6'd1, 6'd0});
        end
    endtask

    task automatic test_fill();
        apply_reset();
        for (int i = 0; i < 32; i++) begin
            drive(2'b11, 1'b0, 1'b0, 2'd0);
            n_cmp++;
            if ({fire, tags, nxtcyc} !== {1'b1, 6'(2*i+1), 6'(2*i), (i == 31)}) begin
                n_err++;
                $display("FAIL fill_cycle%0d: got fire=%b tags=%h nxt=%b, need 1 %h %b", i, fire,
                         tags, nxtcyc, {6'(2*i+1), 6'(2*i)}, (i == 31));
            end
            tick();
        end
        n_cmp++;
        if ({freenum, rrfptr, rrfcyc} !== {7'd0, 6'd0, 1'b1}) begin
            n_err++;
            $display("FAIL fill_end: got free=%0d rp=%0d cyc=%b, need 0 0 1", freenum, rrfptr, rrfcyc);
        end
    endtask

    // Continues from the full state left by test_fill.
    task automatic test_full();
        drive(2'b11, 1'b0, 1'b0, 2'd0);
        n_cmp++;
        if ({allocatable, fire} !== 2'b00) begin
            n_err++;
            $display("FAIL full_req2: got alloc=%b fire=%b, need 0 0", allocatable, fire);
        end
        drive(2'b00, 1'b0, 1'b0, 2'd0);
        n_cmp++;
        if ({allocatable, fire} !== 2'b10) begin
            n_err++;
            $display("FAIL full_req0: got alloc=%b fire=%b, need 1 0", allocatable, fire);
        end
        drive(2'b01, 1'b0, 1'b0, 2'd1);
        n_cmp++;
        if (allocatable !== 1'b0) begin
            n_err++;
            $display("FAIL full_same_cycle_commit: got alloc=%b, need 0", allocatable);
        end
        tick();
        drive(2'b11, 1'b0, 1'b0, 2'd0);
        n_cmp++;
        if ({freenum, allocatable, fire} !== {7'd1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL one_free_req2: got free=%0d alloc=%b fire=%b, need 1 0 0", freenum,
                     allocatable, fire);
        end
        tick();
        drive(2'b10, 1'b0, 1'b0, 2'd0);
        n_cmp++;
        if ({rrfptr, freenum, tags[11:6], valid} !== {6'd0, 7'd1, 6'd0, 2'b10}) begin
            n_err++;
            $display("FAIL one_free_req_slot1: got rp=%0d free=%0d tag1=%0d v=%b, need 0 1 0 10",
                     rrfptr, freenum, tags[11:6], valid);
        end
        tick();
        n_cmp++;
        if ({freenum, rrfptr} !== {7'd0, 6'd1}) begin
            n_err++;
            $display("FAIL one_free_after: got free=%0d rp=%0d, need 0 1", freenum, rrfptr);
        end
    endtask

    task automatic test_slot1_only();
        apply_reset();
        drive(2'b11, 1'b0, 1'b0, 2'd0); tick(); tick();
        drive(2'b01, 1'b0, 1'b0, 2'd0); tick();
        drive(2'b10, 1'b0, 1'b0, 2'd0);
        n_cmp++;
        if ({rrfptr, tags[11:6], valid} !== {6'd5, 6'd5, 2'b10}) begin
            n_err++;
            $display("FAIL slot1_only: got rp=%0d tag1=%0d v=%b, need 5 5 10", rrfptr,
                     tags[11:6], valid);
        end
        tick();
        n_cmp++;
        if (rrfptr !== 6'd6) begin
            n_err++;
            $display("FAIL slot1_only_ptr: got %0d, need 6", rrfptr);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        drive(2'b11, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 10; i++) tick();
        drive(2'b00, 1'b0, 1'b0, 2'd2); tick(); tick();
        drive(2'b11, 1'b0, 1'b1, 2'd2);
        n_cmp++;
        if ({rrfptr, comptr, freenum, fire} !== {6'd20, 6'd4, 7'd48, 1'b0}) begin
            n_err++;
            $display("FAIL flush_pre: got rp=%0d cp=%0d free=%0d fire=%b, need 20 4 48 0", rrfptr,
                     comptr, freenum, fire);
        end
        tick();
        n_cmp++;
        if ({rrfptr, comptr, freenum, rrfcyc} !== {6'd6, 6'd6, 7'd64, 1'b0}) begin
            n_err++;
            $display("FAIL flush_post: got rp=%0d cp=%0d free=%0d cyc=%b, need 6 6 64 0", rrfptr,
                     comptr, freenum, rrfcyc);
        end
    endtask

    task automatic test_com_err();
        apply_reset();
        drive(2'b01, 1'b0, 1'b0, 2'd0); tick();
        drive(2'b00, 1'b0, 1'b0, 2'd2);
        n_cmp++;
        if ({freenum, com_err} !== {7'd63, 1'b0}) begin
            n_err++;
            $display("FAIL com_err_pre: got free=%0d err=%b, need 63 0", freenum, com_err);
        end
        tick();
        drive(2'b00, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if ({freenum, comptr, com_err} !== {7'd64, 6'd1, 1'b1}) begin
            n_err++;
            $display("FAIL com_err_sticky: got free=%0d cp=%0d err=%b, need 64 1 1", freenum,
                     comptr, com_err);
        end
        apply_reset();
        n_cmp++;
        if (com_err !== 1'b0) begin
            n_err++;
            $display("FAIL com_err_reset: got %b, need 0", com_err);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        drive(2'b11, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 7; i++) tick();
        drive(2'b00, 1'b0, 1'b0, 2'd2); tick();
        drive(2'b11, 1'b0, 1'b0, 2'd1);
        #2 reset_i = 1'b1;
        #1;
        n_cmp++;
        if ({freenum, rrfptr, comptr, rrfcyc, com_err, tags} !==
            {7'd64, 6'd0, 6'd0, 1'b0, 1'b0, 6'd1, 6'd0}) begin
            n_err++;
            $display("FAIL async_reset: got free=%0d rp=%0d cp=%0d cyc=%b err=%b tags=%h",
                     freenum, rrfptr, comptr, rrfcyc, com_err, tags);
        end
        apply_reset();
    endtask

    task automatic test_random();
        logic [37:0] exp_v, got_v;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 600 == 599) apply_reset();
            drive(2'($urandom_range(3)), ($urandom_range(7) == 0), ($urandom_range(40) == 0),
                  2'($urandom_range(2)));
            exp_v = model_out(req, stall, flush);
            got_v = {allocatable, fire, tags, valid, freenum, rrfptr, comptr, rrfcyc, nxtcyc,
                     com_err};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL random_cycle%0d: got %h, need %h (req=%b st=%b fl=%b com=%0d)", i,
                         got_v, exp_v, req, stall, flush, com);
            end
            tick();
        end
    endtask

    initial begin
        reset_i = 1'b1;
        req = 2'b00; stall = 1'b0; flush = 1'b0; com = 2'd0;
        test_reset();
        test_fill();
        test_full();
        test_slot1_only();
        test_flush();
        test_com_err();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
